// File: rtl/scan_sel_gen_if.sv
// Handshake bundle between a scan controller and scan_sel_gen: control/config
// inputs towards the sequencer, decoder select/enable and status back.
interface scan_sel_gen_if #(
   parameter int DWELL_W = 8
);
   logic               start;
   logic               stop;
   logic [DWELL_W-1:0] dwell;
   logic [3:0]         ch_mask;
   logic [1:0]         sel;
   logic               en;
   logic               busy;
   logic               wrap;

   modport master (
      output start, stop, dwell, ch_mask,
      input  sel, en, busy, wrap
   );

   modport slave (
      input  start, stop, dwell, ch_mask,
      output sel, en, busy, wrap
   );
endinterface

// File: rtl/scan_sel_gen.sv
// Channel-select sequencer for a 2-to-4 decoder: sweeps the set bits of ch_mask,
// holding each for max(dwell,1) cycles. Define SCAN_BLANK_EN for a one-cycle en=0 gap.
module scan_sel_gen #(
   parameter int DWELL_W = 8
) (
   input logic          clk,
   input logic          rst_n,
   scan_sel_gen_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

   localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   state_t             r_state;
   logic [1:0]         r_sel;
   logic               r_en;
   logic               r_busy;
   logic               r_wrap;
   logic [DWELL_W-1:0] r_cnt;
   logic [3:0]         r_mask;
   logic [DWELL_W-1:0] r_dwell;

   state_t             w_state_next;
   logic [1:0]         w_sel_next;
   logic               w_en_next;
   logic               w_busy_next;
   logic               w_wrap_next;
   logic [DWELL_W-1:0] w_cnt_next;
   logic [3:0]         w_mask_next;
   logic [DWELL_W-1:0] w_dwell_next;

   logic               w_adv;
   logic               w_has_higher;
   logic [1:0]         w_higher;
   logic [1:0]         w_low_in;
   logic [DWELL_W-1:0] w_d_in;
   logic [DWELL_W-1:0] w_d_lat;

   assign w_d_in  = (bus.dwell == '0) ? ONE : bus.dwell;
   assign w_d_lat = (r_dwell == '0) ? ONE : r_dwell;

   // Next higher set bit of the latched mask, and lowest set bit of the live mask.
   always_comb begin
      w_has_higher = 1'b0;
      w_higher     = 2'd0;
      w_low_in     = 2'd0;
      for (int j = 3; j >= 0; j--) begin
         if (j > int'(r_sel) && r_mask[j]) begin
            w_has_higher = 1'b1;
            w_higher     = 2'(j);
         end
         if (bus.ch_mask[j]) begin
            w_low_in = 2'(j);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_en_next    = r_en;
      w_busy_next  = r_busy;
      w_wrap_next  = 1'b0;
      w_cnt_next   = r_cnt;
      w_mask_next  = r_mask;
      w_dwell_next = r_dwell;
      w_adv        = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_sel_next  = 2'd0;
            w_en_next   = 1'b0;
            w_busy_next = 1'b0;
            if (bus.start && !bus.stop && bus.ch_mask != 4'd0) begin
               w_state_next = S_ACTIVE;
               w_mask_next  = bus.ch_mask;
               w_dwell_next = bus.dwell;
               w_sel_next   = w_low_in;
               w_en_next    = 1'b1;
               w_busy_next  = 1'b1;
               w_cnt_next   = w_d_in;
            end
         end
         S_ACTIVE: begin
            if (bus.stop) begin
               w_state_next = S_IDLE;
            end else if (r_cnt > ONE) begin
               w_cnt_next = r_cnt - ONE;
            end else begin
`ifdef SCAN_BLANK_EN
               w_state_next = S_BLANK;
               w_en_next    = 1'b0;
`else
               w_adv = 1'b1;
`endif
            end
         end
`ifdef SCAN_BLANK_EN
         S_BLANK: begin
            if (bus.stop) begin
               w_state_next = S_IDLE;
            end else begin
               w_adv = 1'b1;
            end
         end
`endif
         default: w_state_next = S_IDLE;
      endcase

      if (w_adv) begin
         w_state_next = S_ACTIVE;
         w_en_next    = 1'b1;
         w_busy_next  = 1'b1;
         if (w_has_higher) begin
            w_sel_next = w_higher;
            w_cnt_next = w_d_lat;
         end else if (bus.ch_mask == 4'd0) begin
            w_state_next = S_IDLE;
         end else begin
            // Sweep boundary: pick up the live mask/dwell for the new sweep.
            w_mask_next  = bus.ch_mask;
            w_dwell_next = bus.dwell;
            w_sel_next   = w_low_in;
            w_cnt_next   = w_d_in;
            w_wrap_next  = 1'b1;
         end
      end

      if (w_state_next == S_IDLE) begin
         w_sel_next  = 2'd0;
         w_en_next   = 1'b0;
         w_busy_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sel   <= 2'd0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
         r_cnt   <= '0;
         r_mask  <= 4'd0;
         r_dwell <= '0;
      end else begin
         r_state <= w_state_next;
         r_sel   <= w_sel_next;
         r_en    <= w_en_next;
         r_busy  <= w_busy_next;
         r_wrap  <= w_wrap_next;
         r_cnt   <= w_cnt_next;
         r_mask  <= w_mask_next;
         r_dwell <= w_dwell_next;
      end
   end

   assign bus.sel  = r_sel;
   assign bus.en   = r_en;
   assign bus.busy = r_busy;
   assign bus.wrap = r_wrap;

endmodule

// File: doc/scan_sel_gen.md
# scan_sel_gen

Sequencer that generates the 2-bit channel select and enable consumed by the 2-to-4 decoder (`in`, `en`). It sweeps through the channels enabled in a 4-bit mask, holds each for a programmable dwell time, and optionally inserts a one-cycle blank between channels so the decoded one-hot outputs never overlap. Typical use: digit/row multiplexing, where the decoder's one-hot `out` drives the physical select lines.

## Interface
- `DWELL_W`, default 8: width of the dwell count.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level, sampled in IDLE; begins scanning.
- `stop` input 1: level, sampled in any state; ends scanning.
- `dwell` input DWELL_W: cycles per channel with `en`=1; 0 is treated as 1.
- `ch_mask` input 4: bit i=1 means channel i is visited.
- `sel` output 2: channel index; drives decoder `in`.
- `en` output 1: drives decoder `en`.
- `busy` output 1: 1 in ACTIVE or BLANK.
- `wrap` output 1: one-cycle pulse at the start of each new sweep.

## Operation
- States: IDLE, ACTIVE, BLANK (BLANK exists only with `SCAN_BLANK_EN`).
- All outputs are registered. Reset values: `sel`=0, `en`=0, `busy`=0, `wrap`=0, state=IDLE.
- IDLE:
  - `sel`=0, `en`=0.
  - If `start`=1, `stop`=0 and `ch_mask`≠0: latch `ch_mask` and `dwell`, then go to ACTIVE on the lowest set mask bit.
  - Otherwise stay in IDLE. This covers `start` with `ch_mask`=0, and `start` together with `stop`.
- ACTIVE:
  - `en`=1 and `sel`=current channel for max(latched dwell, 1) consecutive cycles.
  - On the last cycle:
    - With BLANK: go to BLANK.
    - Without BLANK: go straight to ACTIVE on the next channel.
- BLANK: one cycle with `en`=0 and `sel` held at the old channel, then ACTIVE on the next channel.
- Next channel: the next higher set bit of the latched mask, wrapping from the highest set bit to the lowest. With a single set bit, the same channel repeats.
- Sweep boundary: when the next channel is the lowest set bit (wrap-around), re-latch `ch_mask` and `dwell` from the inputs. If the new `ch_mask`=0, go to IDLE instead.
- `wrap`=1 during the first ACTIVE cycle of every sweep after the first. It is not asserted on the first sweep after `start`.
- `stop`=1 in ACTIVE or BLANK: the next cycle is IDLE with `en`=0, `sel`=0, `busy`=0. `stop` has priority over every transition.
- `start` while `busy`=1 is ignored.
- Mask and dwell inputs change freely; only the latched values are used mid-sweep.
- `rst_n` low at any time forces the reset values immediately (asynchronous), including mid-dwell.

## Timing
- Start latency: `start` sampled at edge N gives `busy`=1, `en`=1, `sel`=first channel after edge N.
- Stop latency: `stop` sampled at edge N gives `en`=0, `busy`=0 after edge N.
- Channel period: D cycles without BLANK, D+1 cycles with BLANK, where D = max(dwell, 1).
- Sweep period: K·D without BLANK, K·(D+1) with BLANK, where K = number of set mask bits.
- `en` never stays high across a `sel` change when BLANK is compiled in.
- The dwell counter is DWELL_W bits wide and counts down from D to 1 with no overflow. Maximum D = 2^DWELL_W − 1.

## Configuration
- `SCAN_BLANK_EN` defined:
  - BLANK state is present.
  - One `en`=0 cycle between consecutive channels, including across a wrap.
- `SCAN_BLANK_EN` undefined:
  - No BLANK state.
  - `en` stays 1 continuously while `busy`, and `sel` changes on back-to-back cycles.

## Test plan
- Reset: assert `rst_n`=0 mid-scan → `sel`=0, `en`=0, `busy`=0, `wrap`=0 immediately. Release with `start`=0 → outputs stay at 0.
- Full sweep, no blank: `ch_mask`=1111, `dwell`=2, pulse `start` → `sel` 0,0,1,1,2,2,3,3,0,0 with `en`=1 throughout. `wrap`=1 only on the cycle of the second `sel`=0.
- Sparse mask and dwell 0: `ch_mask`=1010, `dwell`=0 → `sel` alternates 1,3,1,3 each cycle. `wrap` is pulsed on each `sel`=1 after the first.
- Blank mode (`SCAN_BLANK_EN`): `ch_mask`=0011, `dwell`=1 → (`sel`,`en`) = (0,1),(0,0),(1,1),(1,0),(0,1) …
- Stop and ignored start: raise `stop` during the second `sel`=2 cycle → IDLE next cycle. `start` with `ch_mask`=0000 → stays IDLE. `start` and `stop` both 1 → stays IDLE.
- Mask update at sweep boundary: change `ch_mask` 1111→0100 mid-sweep → the current sweep completes on 0–3, then `sel`=2 only. Change to 0000 → IDLE at the next wrap.
